// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t   : arbiter FSM states (IDLE, REQ, WAIT)
//   grant_t   : which requester owns the current transaction
//   SIZE_WORD : size code for a 32-bit access (instruction fetches use it)
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN (see mem_arb_pick).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the memory arbiter.
// Ports:
//   inst_req   in  fetch request
//   data_req   in  data-stage request
//   last_grant in  requester served by the most recently completed transaction
//   winner     out requester to accept; only meaningful when a request is high
// Macro MEM_ARB_RR_EN:
//   defined   -> round robin: on a tie the requester not in last_grant wins
//   undefined -> fixed priority: DATA beats INST on a tie
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  grant_t last_grant,
  output grant_t winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = GNT_INST;
    if (inst_req && data_req) begin
      winner = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
    end else if (data_req) begin
      winner = GNT_DATA;
    end
  end
`else
  // last_grant has no effect on fixed priority; kept on the port so both
  // builds share one interface.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = GNT_INST;
    if (data_req) begin
      winner = GNT_DATA;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// data-access stage, with one transaction outstanding at a time.
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   inst_req/inst_addr           fetch request (always a word read)
//   inst_addr_ok/inst_data_ok    fetch accepted / fetch data valid (1-cycle pulses)
//   inst_rdata                   fetch data (copy of mem_rdata)
//   data_req/wr/size/addr/wdata  data-stage request
//   data_addr_ok/data_data_ok    data accepted / load data valid or store done
//   data_rdata                   load data (copy of mem_rdata)
//   mem_req/wr/size/addr/wdata   downstream request, driven from latched fields
//   mem_addr_ok/mem_data_ok      downstream accept / response
//   mem_rdata                    downstream read data
//   busy                         a transaction is in flight (state != IDLE)
// Macro MEM_ARB_RR_EN selects round-robin tie-breaking (default: DATA priority).
//
// Handshake: a requester holds *_req and its fields until it sees *_addr_ok,
// which pulses in the same cycle the request is seen in IDLE. *_data_ok pulses
// once, one cycle, for the granted requester only. Downstream, mem_req is held
// with stable fields until mem_addr_ok; mem_data_ok is only honoured in WAIT and
// mem_addr_ok only in REQ.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  grant_t        last_grant_q, last_grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [DW-1:0] wdata_q, wdata_d;
  grant_t        winner;

  mem_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          grant_d = winner;
          state_d = REQ;
          if (winner == GNT_DATA) begin
            data_addr_ok = 1'b1;
            addr_d       = data_addr;
            wr_d         = data_wr;
            size_d       = data_size;
            wdata_d      = data_wdata;
          end else begin
            // Fetches are always word reads with no store data.
            inst_addr_ok = 1'b1;
            addr_d       = inst_addr;
            wr_d         = 1'b0;
            size_d       = SIZE_WORD;
            wdata_d      = '0;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          if (grant_q == GNT_DATA) begin
            data_data_ok = 1'b1;
          end else begin
            inst_data_ok = 1'b1;
          end
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_INST;
      last_grant_q <= GNT_INST;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
    end
  end

  // Downstream fields come straight from the latches so they cannot move
  // while mem_req is waiting for mem_addr_ok.
  assign mem_wr     = wr_q;
  assign mem_size   = size_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Inputs change just after
// the falling edge; outputs are sampled 1 ns later, well before the next
// rising edge. Cycle N of each scenario is the Nth falling edge after it starts.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Expected grant order for the tie scenario: 1 = DATA, 0 = INST.
  logic [1:0] exp_q[$];

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_inst_addr_ok"}, {31'd0, inst_addr_ok}, 32'd0);
    check_eq({tag, "_data_addr_ok"}, {31'd0, data_addr_ok}, 32'd0);
    check_eq({tag, "_inst_data_ok"}, {31'd0, inst_data_ok}, 32'd0);
    check_eq({tag, "_data_data_ok"}, {31'd0, data_data_ok}, 32'd0);
    check_eq({tag, "_mem_req"},      {31'd0, mem_req},      32'd0);
    check_eq({tag, "_mem_wr"},       {31'd0, mem_wr},       32'd0);
    check_eq({tag, "_busy"},         {31'd0, busy},         32'd0);
    check_eq({tag, "_mem_addr"},     mem_addr,              32'd0);
    check_eq({tag, "_mem_size"},     {30'd0, mem_size},     32'd0);
    check_eq({tag, "_mem_wdata"},    mem_wdata,             32'd0);
  endtask

  // Code for which requester got an addr_ok this cycle: 0 inst, 1 data, 2 none, 3 both.
  function automatic logic [1:0] accept_code();
    if (inst_addr_ok && data_addr_ok) return 2'd3;
    if (data_addr_ok) return 2'd1;
    if (inst_addr_ok) return 2'd0;
    return 2'd2;
  endfunction

  function automatic logic [1:0] done_code();
    if (inst_data_ok && data_data_ok) return 2'd3;
    if (data_data_ok) return 2'd1;
    if (inst_data_ok) return 2'd0;
    return 2'd2;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_inst_only();
    next_cycle();                      // cycle 0
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    #1;
    check_eq("inst_c0_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    check_eq("inst_c0_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    next_cycle();                      // cycle 1
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    check_eq("inst_c1_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("inst_c1_mem_addr", mem_addr, 32'hBFC0_0000);
    check_eq("inst_c1_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("inst_c1_mem_size", {30'd0, mem_size}, 32'd2);
    check_eq("inst_c1_mem_wdata", mem_wdata, 32'd0);
    check_eq("inst_c1_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    next_cycle();                      // cycle 2
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3C01_0001;
    #1;
    check_eq("inst_c2_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("inst_c2_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check_eq("inst_c2_rdata", inst_rdata, 32'h3C01_0001);
    check_eq("inst_c2_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    next_cycle();                      // cycle 3
    mem_data_ok = 1'b0;
    #1;
    check_eq("inst_c3_busy", {31'd0, busy}, 32'd0);
    check_eq("inst_c3_data_ok", {31'd0, inst_data_ok}, 32'd0);
  endtask

  task automatic test_store();
    next_cycle();                      // cycle 0
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_addr  = 32'h8000_0010;
    data_wdata = 32'h0000_BEEF;
    #1;
    check_eq("st_c0_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    check_eq("st_c0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    next_cycle();                      // cycle 1: REQ, slave stalls one cycle
    clear_inputs();
    #1;
    check_eq("st_c1_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("st_c1_mem_wr", {31'd0, mem_wr}, 32'd1);
    check_eq("st_c1_mem_size", {30'd0, mem_size}, 32'd1);
    check_eq("st_c1_mem_addr", mem_addr, 32'h8000_0010);
    check_eq("st_c1_mem_wdata", mem_wdata, 32'h0000_BEEF);
    next_cycle();                      // cycle 2: still REQ
    mem_addr_ok = 1'b1;
    #1;
    check_eq("st_c2_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("st_c2_mem_addr", mem_addr, 32'h8000_0010);
    check_eq("st_c2_mem_wdata", mem_wdata, 32'h0000_BEEF);
    next_cycle();                      // cycle 3: WAIT, no response yet
    mem_addr_ok = 1'b0;
    #1;
    check_eq("st_c3_data_ok", {31'd0, data_data_ok}, 32'd0);
    check_eq("st_c3_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    next_cycle();                      // cycle 4: response
    mem_data_ok = 1'b1;
    #1;
    check_eq("st_c4_data_ok", {31'd0, data_data_ok}, 32'd1);
    check_eq("st_c4_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    check_eq("st_c4_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    #1;
    check_eq("st_c5_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
`else
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
`endif
    next_cycle();
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC0_0100;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_addr  = 32'h8000_0040;
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      #1;                              // IDLE cycle: acceptance
      check_eq("tie_accept", {30'd0, accept_code()}, {30'd0, exp_g});
      next_cycle();                    // REQ
      mem_addr_ok = 1'b1;
      #1;
      check_eq("tie_mem_addr", mem_addr, exp_g[0] ? 32'h8000_0040 : 32'hBFC0_0100);
      next_cycle();                    // WAIT
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h1234_5678;
      #1;
      check_eq("tie_done", {30'd0, done_code()}, {30'd0, exp_g});
      next_cycle();
      mem_data_ok = 1'b0;
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_slow_slave();
    next_cycle();                      // cycle 0: data load accepted
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h8000_0100;
    #1;
    check_eq("slow_c0_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    // Cycles 1..4: REQ; both requesters keep asking, nothing may be accepted.
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      inst_req    = 1'b1;
      inst_addr   = 32'hBFC0_0200;
      data_addr   = 32'h8000_0FFF;
      mem_addr_ok = (c == 4);
      #1;
      check_eq("slow_req_mem_req", {31'd0, mem_req}, 32'd1);
      check_eq("slow_req_mem_addr", mem_addr, 32'h8000_0100);
      check_eq("slow_req_mem_size", {30'd0, mem_size}, 32'd2);
      check_eq("slow_req_mem_wr", {31'd0, mem_wr}, 32'd0);
      check_eq("slow_req_accept", {30'd0, accept_code()}, 32'd2);
    end
    // Cycles 5..9: WAIT, response arrives on cycle 9.
    for (int c = 5; c <= 9; c++) begin
      next_cycle();
      mem_addr_ok = 1'b0;
      mem_data_ok = (c == 9);
      mem_rdata   = 32'hCAFE_0000 + c;
      if (c == 9) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      #1;
      check_eq("slow_wait_busy", {31'd0, busy}, 32'd1);
      check_eq("slow_wait_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("slow_wait_accept", {30'd0, accept_code()}, 32'd2);
      check_eq("slow_wait_done", {30'd0, done_code()}, (c == 9) ? 32'd1 : 32'd2);
    end
    check_eq("slow_rdata", data_rdata, 32'hCAFE_0009);
    next_cycle();
    clear_inputs();
    #1;
    check_eq("slow_end_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_spurious();
    next_cycle();                      // IDLE, stray response and accept
    mem_data_ok = 1'b1;
    mem_addr_ok = 1'b1;
    #1;
    check_eq("spur_idle_done", {30'd0, done_code()}, 32'd2);
    next_cycle();
    clear_inputs();
    #1;
    check_eq("spur_idle_busy", {31'd0, busy}, 32'd0);
    inst_req  = 1'b1;                  // accept a fetch in this cycle
    inst_addr = 32'hBFC0_0300;
    #1;
    check_eq("spur_accept", {31'd0, inst_addr_ok}, 32'd1);
    next_cycle();                      // REQ with stray mem_data_ok
    inst_req    = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    check_eq("spur_req_done", {30'd0, done_code()}, 32'd2);
    next_cycle();                      // must still be in REQ
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    check_eq("spur_still_req", {31'd0, mem_req}, 32'd1);
    next_cycle();                      // WAIT, real response
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_0ACE;
    #1;
    check_eq("spur_real_done", {30'd0, done_code()}, 32'd0);
    check_eq("spur_rdata", inst_rdata, 32'h0000_0ACE);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    next_cycle();                      // cycle 0: store accepted
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_addr  = 32'h8000_0200;
    data_wdata = 32'h5555_AAAA;
    #1;
    check_eq("rst_c0_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    next_cycle();                      // cycle 1: REQ
    clear_inputs();
    mem_addr_ok = 1'b1;
    next_cycle();                      // cycle 2: WAIT, reset pulsed
    mem_addr_ok = 1'b0;
    rst         = 1'b1;
    #1;
    check_eq("rst_c2_busy", {31'd0, busy}, 32'd1);
    next_cycle();                      // cycle 3: response would land here
    rst         = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    check_idle_outputs("rst_c3");
    next_cycle();
    mem_data_ok = 1'b0;
    #1;
    check_eq("rst_c4_busy", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();
    #1;
    check_idle_outputs("reset");
    test_inst_only();
    test_store();
    do_reset();
    test_tie();
    test_slow_slave();
    test_spurious();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
